// File: rtl/key_extractor_pkg.sv
// Shared layout constants for the PHV, the per-tenant config entry and the
// extracted key. Used by the key extractor, lookup engine and action engine.
package key_extractor_pkg;

  // PHV geometry
  localparam int PHV_W   = 1124;
  localparam int C48_W   = 48;
  localparam int C32_W   = 32;
  localparam int C16_W   = 16;
  localparam int C48_OFF = PHV_W - 1;    // MSB of 48 b container 0
  localparam int C32_OFF = PHV_W - 385;  // MSB of 32 b container 0
  localparam int C16_OFF = PHV_W - 641;  // MSB of 16 b container 0

  // Tenant id lives in the top nibble of the metadata block
  localparam int TENANT_MSB = 255;
  localparam int TENANT_LSB = 252;
  localparam int TENANT_W   = TENANT_MSB - TENANT_LSB + 1;
  localparam int unsigned N_TENANT = 16;

  // Config entry: {valid, sel48_a, sel48_b, sel32_a, sel32_b, sel16_a, sel16_b, mask}
  localparam int SEL_W       = 3;
  localparam int MASK_W      = 192;
  localparam int CFG_ENTRY_W = 1 + 6 * SEL_W + MASK_W;
  localparam int E_VALID     = 210;
  localparam int E_S48A_LSB  = 207;
  localparam int E_S48B_LSB  = 204;
  localparam int E_S32A_LSB  = 201;
  localparam int E_S32B_LSB  = 198;
  localparam int E_S16A_LSB  = 195;
  localparam int E_S16B_LSB  = 192;
  localparam int MASK_MSB    = 191;

  // Key: 192 masked field bits followed by the 5-bit {valid, tenant} tag
  localparam int KEY_FIELDS_W = 2 * C48_W + 2 * C32_W + 2 * C16_W;
  localparam int KEY_W        = KEY_FIELDS_W + 1 + TENANT_W;

  typedef logic [PHV_W-1:0]       phv_t;
  typedef logic [CFG_ENTRY_W-1:0] cfg_entry_t;
  typedef logic [KEY_W-1:0]       key_t;

  // Container selectors: container i sits i widths below the class base
  function automatic logic [C48_W-1:0] get_c48(input phv_t phv, input logic [SEL_W-1:0] sel);
    return phv[C48_OFF - C48_W * int'(sel) -: C48_W];
  endfunction

  function automatic logic [C32_W-1:0] get_c32(input phv_t phv, input logic [SEL_W-1:0] sel);
    return phv[C32_OFF - C32_W * int'(sel) -: C32_W];
  endfunction

  function automatic logic [C16_W-1:0] get_c16(input phv_t phv, input logic [SEL_W-1:0] sel);
    return phv[C16_OFF - C16_W * int'(sel) -: C16_W];
  endfunction

endpackage

// File: rtl/key_extract_cfg_ram.sv
// Per-tenant config table: 16 entries, async clear, one write port and one
// registered read port. A read and write to the same address on the same
// edge returns the old contents.
module key_extract_cfg_ram
  import key_extractor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [TENANT_W-1:0] wr_addr_i,
  input  cfg_entry_t          wr_data_i,
  input  logic [TENANT_W-1:0] rd_addr_i,
  output cfg_entry_t          rd_data_o
);

  cfg_entry_t mem_q [N_TENANT];
  cfg_entry_t rd_q;

  // Table storage and registered read; the read samples pre-write contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_TENANT; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr_i];
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/key_extractor.sv
// Per-stage key extractor: selects six PHV containers by tenant config,
// masks them, appends {valid, tenant} and emits the key with the aligned PHV
// two register stages later.
module key_extractor
  import key_extractor_pkg::*;
#(
  parameter int STAGE   = 0,
  parameter int PHV_LEN = 1124,
  parameter int KEY_LEN = 197,
  parameter int ENTRY_W = 211
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic [KEY_LEN-1:0] extract_key,
  output logic               key_valid,
  output logic [PHV_LEN-1:0] phv_out,
  input  logic               cfg_wr_en,
  input  logic [3:0]         cfg_wr_addr,
  input  logic [ENTRY_W-1:0] cfg_wr_data
);

  // The field layout is fixed by the shared package; reject mismatched overrides
  if (PHV_LEN != PHV_W || KEY_LEN != KEY_W || ENTRY_W != CFG_ENTRY_W || STAGE < 0) begin : g_param_check
    $error("key_extractor: parameters do not match the shared layout");
  end

  phv_t                phv1_q;
  logic                vld1_q;
  logic [TENANT_W-1:0] tenant1_q;
  cfg_entry_t          entry1;

  key_t  key_d;
  key_t  key_q;
  logic  key_valid_q;
  phv_t  phv2_q;

  // S1 table read, addressed straight from the incoming PHV so the entry
  // lands alongside the S1 registers
  key_extract_cfg_ram u_cfg_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cfg_wr_en),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_addr_i (phv_in[TENANT_MSB:TENANT_LSB]),
    .rd_data_o (entry1)
  );

  // S1 pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv1_q    <= '0;
      vld1_q    <= 1'b0;
      tenant1_q <= '0;
    end else begin
      phv1_q    <= phv_in;
      vld1_q    <= phv_valid_in;
      tenant1_q <= phv_in[TENANT_MSB:TENANT_LSB];
    end
  end

  // S2 key build: select containers, mask, append the unmasked tag
  always_comb begin
    key_d = '0;
    key_d[KEY_W-1 -: KEY_FIELDS_W] =
      { get_c48(phv1_q, entry1[E_S48A_LSB +: SEL_W]),
        get_c48(phv1_q, entry1[E_S48B_LSB +: SEL_W]),
        get_c32(phv1_q, entry1[E_S32A_LSB +: SEL_W]),
        get_c32(phv1_q, entry1[E_S32B_LSB +: SEL_W]),
        get_c16(phv1_q, entry1[E_S16A_LSB +: SEL_W]),
        get_c16(phv1_q, entry1[E_S16B_LSB +: SEL_W]) }
      & entry1[MASK_MSB:0];
    key_d[TENANT_W:0] = {entry1[E_VALID], tenant1_q};
  end

  // S2 output registers; data holds across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
      phv2_q      <= '0;
    end else begin
      key_valid_q <= vld1_q;
      if (vld1_q) begin
        key_q  <= key_d;
        phv2_q <= phv1_q;
      end
    end
  end

  assign extract_key = key_q;
  assign key_valid   = key_valid_q;
  assign phv_out     = phv2_q;

endmodule

// File: tb/tb_key_extractor.sv
// Directed self-checking bench for key_extractor.
module tb_key_extractor;

  logic          clk = 1'b0;
  logic          rst;
  logic [1123:0] phv_in;
  logic          phv_valid_in;
  logic [196:0]  extract_key;
  logic          key_valid;
  logic [1123:0] phv_out;
  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_addr;
  logic [210:0]  cfg_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_extractor #(
    .STAGE   (0),
    .PHV_LEN (1124),
    .KEY_LEN (197),
    .ENTRY_W (211)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .phv_in       (phv_in),
    .phv_valid_in (phv_valid_in),
    .extract_key  (extract_key),
    .key_valid    (key_valid),
    .phv_out      (phv_out),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data)
  );

  task automatic chk(input string tag, input logic [1123:0] obs, input logic [1123:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed(low200)=%0h expected(low200)=%0h", tag, obs[199:0], exp[199:0]);
    end
  endtask

  // Every container i of each class holds base+i; reserved bits set, metadata patterned
  function automatic logic [1123:0] mk_phv(input logic [3:0] ten, input logic [7:0] base);
    logic [1123:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[1123 - 48*i -: 48] = 48'(base + 8'(i));
      p[739  - 32*i -: 32] = 32'(base + 8'(i));
      p[483  - 16*i -: 16] = 16'(base + 8'(i));
    end
    p[355:256] = {100{1'b1}};
    p[251:0]   = {63{4'h5}};
    p[255:252] = ten;
    return p;
  endfunction

  function automatic logic [210:0] mk_entry(input logic v,
      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
      input logic [2:0] d, input logic [2:0] e, input logic [2:0] f,
      input logic [191:0] m);
    return {v, a, b, c, d, e, f, m};
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [210:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
  endtask

  // Drive one PHV and return at the negedge where its key is visible
  task automatic send_one(input logic [1123:0] p);
    phv_in       = p;
    phv_valid_in = 1'b1;
    @(negedge clk);
    phv_valid_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [1123:0] p;
    logic [1123:0] p2;
    logic [191:0]  ones;
    logic [7:0]    bk;
    logic [196:0]  ek;

    ones         = '1;
    rst          = 1'b1;
    phv_in       = '0;
    phv_valid_in = 1'b0;
    cfg_wr_en    = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_key",   extract_key, '0);
    chk("rst_valid", key_valid,   '0);
    chk("rst_phv",   phv_out,     '0);
    rst = 1'b0;
    @(negedge clk);

    // Unconfigured tenant 3: mask 0, valid 0, tag only
    p = mk_phv(4'd3, 8'h11);
    phv_in       = p;
    phv_valid_in = 1'b1;
    @(negedge clk);
    phv_valid_in = 1'b0;
    chk("t1_not_yet", key_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", key_valid,   1'b1);
    chk("t1_key",   extract_key, 197'h03);
    chk("t1_phv",   phv_out,     p);
    @(negedge clk);
    chk("t1_bubble", key_valid,   1'b0);
    chk("t1_hold",   extract_key, 197'h03);

    // Entry 2, full mask
    cfg_write(4'd2, mk_entry(1'b1, 3'd1, 3'd7, 3'd0, 3'd5, 3'd2, 3'd6, ones));
    p = mk_phv(4'd2, 8'hA0);
    send_one(p);
    chk("t2_valid", key_valid, 1'b1);
    chk("t2_key", extract_key,
        {48'hA1, 48'hA7, 32'hA0, 32'hA5, 16'hA2, 16'hA6, 5'h12});
    chk("t2_phv", phv_out, p);

    // Entry 2, mask only the first 48 b field
    cfg_write(4'd2, mk_entry(1'b1, 3'd1, 3'd7, 3'd0, 3'd5, 3'd2, 3'd6,
                             {48'hFFFF_FFFF_FFFF, 144'h0}));
    send_one(p);
    chk("t3_valid", key_valid, 1'b1);
    chk("t3_key", extract_key, {48'hA1, 144'h0, 5'h12});

    // Entries 0..7 select 48 b container k; stream 8 back-to-back PHVs
    for (int k = 0; k < 8; k++) begin
      cfg_write(4'(k), mk_entry(1'b1, 3'(k), 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, ones));
    end
    for (int t = 0; t < 10; t++) begin
      if (t >= 2) begin
        bk = 8'h10 * 8'(t - 1);
        ek = {48'(bk + 8'(t - 2)), 48'(bk), 32'(bk), 32'(bk), 16'(bk), 16'(bk),
              1'b1, 4'(t - 2)};
        chk($sformatf("t4_valid_%0d", t - 2), key_valid, 1'b1);
        chk($sformatf("t4_key_%0d", t - 2), extract_key, ek);
      end
      if (t < 8) begin
        phv_in       = mk_phv(4'(t), 8'h10 * 8'(t + 1));
        phv_valid_in = 1'b1;
      end else begin
        phv_valid_in = 1'b0;
      end
      @(negedge clk);
    end
    chk("t4_after", key_valid, 1'b0);

    // Read-before-write on entry 4
    phv_in       = mk_phv(4'd4, 8'h50);
    phv_valid_in = 1'b1;
    cfg_wr_en    = 1'b1;
    cfg_wr_addr  = 4'd4;
    cfg_wr_data  = mk_entry(1'b1, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, ones);
    @(negedge clk);
    cfg_wr_en = 1'b0;
    phv_in    = mk_phv(4'd4, 8'h60);
    @(negedge clk);
    phv_valid_in = 1'b0;
    chk("t5_old_valid", key_valid, 1'b1);
    chk("t5_old_key", extract_key,
        {48'h54, 48'h50, 32'h50, 32'h50, 16'h50, 16'h50, 5'h14});
    @(negedge clk);
    chk("t5_new_valid", key_valid, 1'b1);
    chk("t5_new_key", extract_key,
        {48'h67, 48'h67, 32'h60, 32'h60, 16'h60, 16'h60, 5'h14});

    // Reset with two PHVs in flight; config write during reset is ignored
    @(negedge clk);
    phv_in       = mk_phv(4'd0, 8'h20);
    phv_valid_in = 1'b1;
    @(negedge clk);
    phv_in      = mk_phv(4'd0, 8'h30);
    rst         = 1'b1;
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'd5;
    cfg_wr_data = mk_entry(1'b1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, ones);
    @(negedge clk);
    phv_valid_in = 1'b0;
    chk("t6_rst_valid", key_valid,   1'b0);
    chk("t6_rst_key",   extract_key, '0);
    chk("t6_rst_phv",   phv_out,     '0);
    @(negedge clk);
    rst       = 1'b0;
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk("t6_drop_a", key_valid, 1'b0);
    @(negedge clk);
    chk("t6_drop_b", key_valid, 1'b0);

    p2 = mk_phv(4'd5, 8'h30);
    send_one(p2);
    chk("t6_t5_valid", key_valid,   1'b1);
    chk("t6_t5_key",   extract_key, 197'h05);
    chk("t6_t5_phv",   phv_out,     p2);
    send_one(mk_phv(4'd0, 8'h40));
    chk("t6_t0_valid", key_valid,   1'b1);
    chk("t6_t0_key",   extract_key, 197'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
